// File: rtl/add_acc_pipe.sv
// Pipelined add/sub/accumulate unit with valid/ready handshakes on both sides.
// STAGES=2 splits the adder at WIDTH/2 and registers the low-half carry between stages.
module add_acc_pipe #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned STAGES   = 2,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             ovf
);

    localparam int unsigned H = WIDTH / 2;

    logic             stall;
    logic             acc_hazard;
    logic             accept;
    logic [WIDTH-1:0] acc_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_q;
    logic             carry_q;
    logic             ovf_q;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall && !acc_hazard;
    assign accept   = in_valid && in_ready;

    // Sub is A + ~B + 1, accumulate is ACC + A, load is A + 0.
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic [H:0]       lo_sum;

    always_comb begin
        op_a   = in1;
        op_b   = '0;
        op_cin = 1'b0;
        case (mode)
            2'b00: op_b = in2;
            2'b01: begin
                op_b   = ~in2;
                op_cin = 1'b1;
            end
            2'b10: begin
                op_a = acc_q;
                op_b = in1;
            end
            default: op_b = '0;
        endcase
    end

    assign lo_sum = {1'b0, op_a[H-1:0]} + {1'b0, op_b[H-1:0]} + {{H{1'b0}}, op_cin};

    // Inputs to the final (output) stage.
    logic         f_valid;
    logic [1:0]   f_mode;
    logic [H-1:0] f_a_hi;
    logic [H-1:0] f_b_hi;
    logic [H-1:0] f_lo;
    logic         f_c;

    generate
        if (STAGES == 1) begin : g_single
            assign f_valid    = accept;
            assign f_mode     = mode;
            assign f_a_hi     = op_a[WIDTH-1:H];
            assign f_b_hi     = op_b[WIDTH-1:H];
            assign f_lo       = lo_sum[H-1:0];
            assign f_c        = lo_sum[H];
            assign acc_hazard = 1'b0;
        end else begin : g_split
            logic         s1_valid_q;
            logic [1:0]   s1_mode_q;
            logic [H-1:0] s1_a_hi_q;
            logic [H-1:0] s1_b_hi_q;
            logic [H-1:0] s1_lo_q;
            logic         s1_c_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid_q <= 1'b0;
                    s1_mode_q  <= 2'b00;
                    s1_a_hi_q  <= '0;
                    s1_b_hi_q  <= '0;
                    s1_lo_q    <= '0;
                    s1_c_q     <= 1'b0;
                end else if (!stall) begin
                    s1_valid_q <= accept;
                    if (accept) begin
                        s1_mode_q <= mode;
                        s1_a_hi_q <= op_a[WIDTH-1:H];
                        s1_b_hi_q <= op_b[WIDTH-1:H];
                        s1_lo_q   <= lo_sum[H-1:0];
                        s1_c_q    <= lo_sum[H];
                    end
                end
            end

            assign f_valid    = s1_valid_q;
            assign f_mode     = s1_mode_q;
            assign f_a_hi     = s1_a_hi_q;
            assign f_b_hi     = s1_b_hi_q;
            assign f_lo       = s1_lo_q;
            assign f_c        = s1_c_q;
            // ACC is read at acceptance, so an ACC op in stage 1 blocks the next one.
            assign acc_hazard = s1_valid_q && s1_mode_q[1];
        end
    endgenerate

    logic [H:0]       hi_sum;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_ovf;

    always_comb begin
        hi_sum  = {1'b0, f_a_hi} + {1'b0, f_b_hi} + {{H{1'b0}}, f_c};
        raw     = {hi_sum[H-1:0], f_lo};
        res_ovf = (f_mode != 2'b11) && (f_a_hi[H-1] == f_b_hi[H-1])
                  && (raw[WIDTH-1] != f_a_hi[H-1]);
        case (f_mode)
            2'b01:   res_c = !hi_sum[H];
            2'b11:   res_c = 1'b0;
            default: res_c = hi_sum[H];
        endcase
        res = raw;
        if (SATURATE && res_ovf) begin
            res = f_a_hi[H-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
        end else if (!stall) begin
            out_valid_q <= f_valid;
            if (f_valid) begin
                out_q   <= res;
                carry_q <= res_c;
                ovf_q   <= res_ovf;
                if (f_mode[1]) begin
                    acc_q <= res;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_acc_pipe.sv
// Scoreboard bench for add_acc_pipe: a wrapping and a saturating instance share one stimulus.
module tb_add_acc_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in1 = '0;
    logic [15:0] in2 = '0;
    logic [1:0]  mode = 2'b00;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, carry, ovf;
    logic [15:0] out;
    logic        in_ready_s, out_valid_s, carry_s, ovf_s;
    logic [15:0] out_s;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int last_accept_cyc = 0;

    logic [17:0] q[$];
    logic [17:0] qs[$];
    logic [15:0] m_acc = '0;
    logic [15:0] m_acc_s = '0;

    add_acc_pipe #(.WIDTH(16), .STAGES(2), .SATURATE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .carry(carry), .ovf(ovf)
    );

    add_acc_pipe #(.WIDTH(16), .STAGES(2), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in1(in1), .in2(in2), .mode(mode), .out_valid(out_valid_s), .out_ready(out_ready),
        .out(out_s), .carry(carry_s), .ovf(ovf_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: {ovf, carry, out} from 17-bit arithmetic.
    function automatic logic [17:0] model(input logic [1:0] m, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] acc,
                                          input bit sat);
        logic [16:0] s;
        logic [15:0] x, y, r;
        logic        c, o;
        x = a;
        y = b;
        o = 1'b0;
        case (m)
            2'b00: begin
                s = {1'b0, x} + {1'b0, y};
                o = (x[15] == y[15]) && (s[15] != x[15]);
            end
            2'b01: begin
                s = {1'b0, x} - {1'b0, y};
                o = (x[15] != y[15]) && (s[15] != x[15]);
            end
            2'b10: begin
                x = acc;
                y = a;
                s = {1'b0, x} + {1'b0, y};
                o = (x[15] == y[15]) && (s[15] != x[15]);
            end
            default: s = {1'b0, a};
        endcase
        c = (m == 2'b11) ? 1'b0 : s[16];
        r = s[15:0];
        if (sat && o) r = x[15] ? 16'h8000 : 16'h7FFF;
        return {o, c, r};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (q.size() == 0) begin
                $display("FAIL wrap_result: got unexpected %h, required no output", {ovf, carry, out});
            end else begin
                logic [17:0] e;
                e = q.pop_front();
                if ({ovf, carry, out} !== e)
                    $display("FAIL wrap_result: got ovf/carry/out %h, required %h", {ovf, carry, out}, e);
                else n_pass++;
            end
        end
        if (rst_n && out_valid_s && out_ready) begin
            n_checks++;
            if (qs.size() == 0) begin
                $display("FAIL sat_result: got unexpected %h, required no output", {ovf_s, carry_s, out_s});
            end else begin
                logic [17:0] e;
                e = qs.pop_front();
                if ({ovf_s, carry_s, out_s} !== e)
                    $display("FAIL sat_result: got ovf/carry/out %h, required %h", {ovf_s, carry_s, out_s}, e);
                else n_pass++;
            end
        end
    end

    task automatic send(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
        bit done;
        logic [17:0] e;
        done = 1'b0;
        mode = m;
        in1 = a;
        in2 = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                last_accept_cyc = cyc;
                e = model(m, a, b, m_acc, 1'b0);
                q.push_back(e);
                if (m[1]) m_acc = e[15:0];
                e = model(m, a, b, m_acc_s, 1'b1);
                qs.push_back(e);
                if (m[1]) m_acc_s = e[15:0];
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles, required acceptance");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (q.size() == 0 && qs.size() == 0) break;
        end
        n_checks++;
        if (q.size() + qs.size() != 0)
            $display("FAIL drain: got %0d results outstanding, required 0", q.size() + qs.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({out_valid, out, carry, ovf} !== 19'd0)
            $display("FAIL reset_outputs: got %h, required 0", {out_valid, out, carry, ovf});
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        int acc_c;
        int lat;
        send(2'b00, 16'h1234, 16'h0101);
        acc_c = last_accept_cyc;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - acc_c;
                break;
            end
        end
        n_checks++;
        if (lat != 2) $display("FAIL latency: got %0d cycles, required 2", lat);
        else n_pass++;
        wait_drain();
        @(posedge clk);
        #1;
    endtask

    task automatic test_carry();
        send(2'b00, 16'hFFFF, 16'h0001);
        send(2'b01, 16'h0000, 16'h0001);
        send(2'b01, 16'h0005, 16'h0003);
        send(2'b00, 16'h8000, 16'h8000);
        wait_drain();
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        send(2'b00, 16'h7FFF, 16'h0001);
        send(2'b01, 16'h8000, 16'h0001);
        send(2'b01, 16'h7FFF, 16'hFFFF);
        send(2'b11, 16'h7FF0, 16'h0000);
        send(2'b10, 16'h0020, 16'h0000);
        send(2'b10, 16'h0001, 16'h0000);
        wait_drain();
        @(posedge clk);
        #1;
    endtask

    task automatic test_acc_hazard();
        int load_c;
        send(2'b11, 16'h0005, 16'h0000);
        load_c = last_accept_cyc;
        mode = 2'b10;
        in1 = 16'h0003;
        in_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL hazard_in_ready: got %b, required 0", in_ready);
        else n_pass++;
        send(2'b10, 16'h0003, 16'h0000);
        n_checks++;
        if (last_accept_cyc - load_c != 2)
            $display("FAIL hazard_gap: got %0d cycles, required 2", last_accept_cyc - load_c);
        else n_pass++;
        wait_drain();
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int first_c;
        logic [31:0] r;
        for (int i = 0; i < 8; i++) begin
            r = $urandom();
            send({1'b0, r[0]}, r[31:16], 16'($urandom()));
            if (i == 0) first_c = last_accept_cyc;
        end
        n_checks++;
        if (last_accept_cyc - first_c != 7)
            $display("FAIL back_to_back: got %0d cycles for 8 ops, required 7", last_accept_cyc - first_c);
        else n_pass++;
        wait_drain();
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        fork
            begin
                for (int i = 0; i < 6; i++) send(2'b00, 16'(16'h1111 * (i + 1)), 16'h0203);
            end
            begin
                logic [17:0] held;
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                n_checks++;
                if (!seen) $display("FAIL stall_start: got out_valid=0, required 1");
                else n_pass++;
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    if (i == 0) held = {ovf, carry, out};
                    else begin
                        n_checks++;
                        if ({ovf, carry, out} !== held)
                            $display("FAIL stall_hold: got %h, required %h", {ovf, carry, out}, held);
                        else n_pass++;
                    end
                    n_checks++;
                    if ({out_valid, in_ready, in_ready_s} !== 3'b100)
                        $display("FAIL stall_ready: got valid/ready/ready_s %b, required 100",
                                 {out_valid, in_ready, in_ready_s});
                    else n_pass++;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_inflight();
        send(2'b00, 16'h0100, 16'h0023);
        send(2'b00, 16'h0200, 16'h0045);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out} !== 17'd0)
            $display("FAIL inflight_reset: got valid/out %h, required 0", {out_valid, out});
        else n_pass++;
        q.delete();
        qs.delete();
        m_acc = '0;
        m_acc_s = '0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL inflight_in_ready: got %b, required 1", in_ready);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL inflight_no_pulse: got out_valid=%b, required 0", out_valid);
            else n_pass++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        send(2'b10, 16'h0004, 16'h0000);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_carry();
        test_overflow();
        test_acc_hazard();
        test_back_to_back();
        test_stall();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/add_acc_pipe.md
ADD_ACC_PIPE -- requirements
Module: add_acc_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (>= 4, even).
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth: 1 = single registered add; 2 = low half added in stage 1, high half in stage 2.
REQ-003 SHALL have parameter SATURATE, default 0, 1 = clamp signed overflow to signed max/min.
REQ-004 SHALL have ports: clk input 1 (clock); rst_n input 1 (reset).
REQ-005 SHALL have ports: in_valid input 1 (operands valid); in_ready output 1 (block accepts operands).
REQ-006 SHALL have ports: in1 input WIDTH (operand A); in2 input WIDTH (operand B).
REQ-007 SHALL have port mode input 2 (00 add A+B, 01 sub A-B, 10 accumulate ACC+A, 11 load ACC=A). in2 is ignored for 10/11.
REQ-008 SHALL have ports: out_valid output 1 (result valid); out_ready input 1 (consumer accepts).
REQ-009 SHALL have ports: out output WIDTH (result); carry output 1 (unsigned carry on add/acc, borrow on sub, 0 on load); ovf output 1 (signed overflow, 0 on load).
REQ-010 SHALL use one clock, clk, rising edge; reset rst_n asynchronous, active-low.

Function
REQ-011 SHALL accept a transfer on the clk edge where in_valid && in_ready; inputs not sampled otherwise.
REQ-012 SHALL define stall = out_valid && !out_ready; while stall, all pipeline registers, ACC and outputs hold.
REQ-013 SHALL drive in_ready = !stall && !acc_hazard (acc_hazard defined in REQ-018).
REQ-014 SHALL present the result of an accepted transfer with out_valid=1 exactly STAGES cycles after acceptance, absent stalls; each stall cycle adds one cycle.
REQ-015 SHALL complete an output transfer on the edge where out_valid && out_ready; out_valid SHALL drop next cycle unless a new result advances.
REQ-016 SHALL sustain one result per cycle for back-to-back add/sub with out_ready held 1.
REQ-017 SHALL compute in WIDTH+1 bits: carry = bit WIDTH of sum (add/acc) or borrow (sub); ovf = signed overflow of the WIDTH-bit two's-complement operation; results wrap modulo 2^WIDTH when SATURATE=0.
REQ-018 SHALL hold an internal WIDTH-bit accumulator ACC, updated when an acc/load op leaves the final stage; with STAGES=2, acc_hazard=1 while an acc/load op is in stage 1, so consecutive ACC ops are separated by one bubble.
REQ-019 SHALL, when SATURATE=1 and ovf=1, drive out (and ACC for mode 10) to 0111..1 on positive overflow, 1000..0 on negative overflow; ovf still reports 1, carry unaffected.
REQ-020 SHALL, for STAGES=2, register the low-half carry between stages so the final out/carry/ovf equal the single-cycle result bit-exactly.
REQ-021 SHALL keep out, carry, ovf stable while out_valid && !out_ready.
REQ-022 SHALL flag no error for mode changes between transfers; each transfer carries its own mode down the pipe.

Reset
REQ-023 SHALL, on rst_n low, asynchronously clear out, carry, ovf, out_valid, ACC and all stage valid bits to 0; in-flight operations are discarded.
REQ-024 SHALL drive in_ready=1 in the first cycle after rst_n deasserts.
REQ-025 SHALL produce no out_valid pulse caused by pre-reset data.

Verification (WIDTH=16, STAGES=2, out_ready=1 unless stated)
REQ-026 add 0x1234+0x0101 accepted at cycle N -> out=0x1335, carry=0, ovf=0, out_valid at N+2.
REQ-027 add 0xFFFF+0x0001 -> out=0x0000, carry=1, ovf=0; sub 0x0000-0x0001 -> out=0xFFFF, carry=1, ovf=0.
REQ-028 add 0x7FFF+0x0001: SATURATE=0 -> out=0x8000, ovf=1; SATURATE=1 -> out=0x7FFF, ovf=1; sub 0x8000-0x0001 with SATURATE=1 -> 0x8000, ovf=1.
REQ-029 load 0x0005 then accumulate 0x0003 offered back-to-back -> in_ready low one cycle after load accept; outputs 0x0005 then 0x0008 in order.
REQ-030 out_ready low 3 cycles while out_valid=1 with stream of adds -> out held stable, in_ready=0, no result lost or duplicated; all results emerge in order after release.
REQ-031 rst_n pulsed low with two ops in flight -> out_valid=0 and out=0 immediately; next accumulate ACC+0x0004 after reset -> out=0x0004.
